// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared geometry constants and enums for the text-screen RAM arbiter.
package vga_text_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 7;

    typedef enum logic {IDLE, FILL} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_DISP, SRC_FILL, SRC_HOST} src_t;
endpackage

// File: rtl/vga_cell_addr.sv
// vga_cell_addr: linear cell address row*COLS+col, shift-add when COLS is 80.
module vga_cell_addr
    import vga_text_pkg::*;
#(
    parameter int COLS   = vga_text_pkg::COLS,
    parameter int ADDR_W = vga_text_pkg::ADDR_W
) (
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);
    generate
        if (COLS == 80) begin : g_shift_add
            assign addr = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
        end else begin : g_mul
            assign addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
        end
    endgenerate
endmodule

// File: rtl/vga_text_ram_arbiter.sv
// vga_text_ram_arbiter: shares one character RAM between display fetch, fill engine and host writes.
module vga_text_ram_arbiter
    import vga_text_pkg::*;
#(
    parameter int COLS   = vga_text_pkg::COLS,
    parameter int ROWS   = vga_text_pkg::ROWS,
    parameter int ADDR_W = vga_text_pkg::ADDR_W,
    parameter int DATA_W = vga_text_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [8:0]        pixel_y,
    output logic [DATA_W-1:0] char_code,
    output logic              char_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [6:0]        wr_col,
    input  logic [4:0]        wr_row,
    input  logic [DATA_W-1:0] wr_char,
    output logic              wr_drop,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_char,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int NCELLS = COLS * ROWS;

    state_t            state;
    src_t              src;
    logic [ADDR_W-1:0] cnt, disp_addr, host_addr;
    logic [DATA_W-1:0] fill_val;
    logic              disp_req, host_ok, hs, last, rd1, rd2;
    logic              unused_ok;

    assign unused_ok = ^pixel_y[3:0];
    assign disp_req  = pix_tick & video_on & (pixel_x[2:0] == 3'd0);
    assign wr_ready  = (state == IDLE) & !disp_req & !fill_start;
    assign hs        = wr_valid & wr_ready;
    assign host_ok   = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign last      = (cnt == ADDR_W'(NCELLS - 1));
    assign fill_busy = (state == FILL);

    vga_cell_addr #(.COLS(COLS), .ADDR_W(ADDR_W)) u_disp_addr (
        .row (pixel_y[8:4]),
        .col (pixel_x[9:3]),
        .addr(disp_addr)
    );

    vga_cell_addr #(.COLS(COLS), .ADDR_W(ADDR_W)) u_host_addr (
        .row (wr_row),
        .col (wr_col),
        .addr(host_addr)
    );

    // Display fetch has fixed timing, so it always wins; fill starves the host
    always_comb begin
        src = disp_req ? SRC_DISP :
              (state == FILL) ? SRC_FILL :
              (hs & host_ok) ? SRC_HOST : SRC_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_val   <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd1        <= 1'b0;
            rd2        <= 1'b0;
            char_code  <= '0;
            char_valid <= 1'b0;
            wr_drop    <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            ram_en     <= (src != SRC_NONE);
            ram_we     <= (src == SRC_FILL) || (src == SRC_HOST);
            ram_addr   <= (src == SRC_DISP) ? disp_addr :
                          (src == SRC_FILL) ? cnt :
                          (src == SRC_HOST) ? host_addr : '0;
            ram_wdata  <= (src == SRC_FILL) ? fill_val :
                          (src == SRC_HOST) ? wr_char : '0;
            // rd1: read on RAM pins, rd2: rdata valid, then capture
            rd1        <= (src == SRC_DISP);
            rd2        <= rd1;
            char_valid <= rd2;
            if (rd2)
                char_code <= ram_rdata;
            wr_drop    <= hs & !host_ok;
            fill_done  <= (src == SRC_FILL) && last;
            if (state == IDLE && fill_start) begin
                state    <= FILL;
                cnt      <= '0;
                fill_val <= fill_char;
            end else if (src == SRC_FILL) begin
                cnt <= last ? '0 : cnt + ADDR_W'(1);
                if (last)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vga_text_ram_arbiter.sv
// tb_vga_text_ram_arbiter: randomized scoreboard bench with a screen-image reference model.
module tb_vga_text_ram_arbiter;
    import vga_text_pkg::*;

    typedef struct { int addr; int cyc; } rd_t;
    typedef struct { int ch; int cyc; } cv_t;
    typedef struct { bit drop; int addr; int ch; int cyc; } hw_t;

    logic              clk = 0, reset = 1;
    logic              pix_tick = 0, video_on = 0;
    logic [9:0]        pixel_x = 0;
    logic [8:0]        pixel_y = 0;
    logic [DATA_W-1:0] char_code;
    logic              char_valid;
    logic              wr_valid = 0, wr_ready, wr_drop;
    logic [6:0]        wr_col = 0;
    logic [4:0]        wr_row = 0;
    logic [DATA_W-1:0] wr_char = 0, fill_char = 0;
    logic              fill_start = 0, fill_busy, fill_done;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0] ref_mem [0:CELLS-1] = '{default: '0};

    rd_t q_rd[$];
    cv_t q_cv[$];
    hw_t q_hw[$];

    int  n_tests = 0, n_fail = 0, cyc = 0;
    int  fill_idx = 0, start_cyc = 0, abort_cells = 0, phase = 0;
    bit  filling = 0, vid_rand = 0;
    logic [DATA_W-1:0] fill_val = 0;

    vga_text_ram_arbiter dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .char_code(char_code), .char_valid(char_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .wr_drop(wr_drop), .fill_start(fill_start), .fill_char(fill_char),
        .fill_busy(fill_busy), .fill_done(fill_done), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: consumes expectations queued from observed stimulus
    always @(negedge clk) begin
        bit  due, dreq;
        hw_t h;
        rd_t r;
        cv_t c;
        if (reset) begin
            if (filling)
                for (int i = 0; i < abort_cells; i++) ref_mem[i] = fill_val;
            filling = 0;
            q_rd.delete(); q_cv.delete(); q_hw.delete();
        end else begin
            due = q_hw.size() > 0 && q_hw[0].cyc + 1 == cyc;
            if (due) begin
                h = q_hw.pop_front();
                if (h.drop)
                    chk("host_drop", {wr_drop, ram_en}, 2'b10);
                else
                    chk("host_write", {wr_drop, ram_en, ram_we, ram_addr, ram_wdata},
                        {1'b0, 1'b1, 1'b1, 12'(h.addr), 7'(h.ch)});
            end else if (ram_en && ram_we) begin
                if (filling) begin
                    chk("fill_write", {ram_addr, ram_wdata}, {12'(fill_idx), fill_val});
                    fill_idx++;
                end else chk("unexpected_write", 1, 0);
            end
            if (!due && wr_drop) chk("spurious_drop", 1, 0);
            if (ram_en && !ram_we) begin
                if (q_rd.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    r = q_rd.pop_front();
                    chk("read_addr", ram_addr, r.addr);
                    chk("read_latency", cyc - r.cyc, 1);
                    c.ch  = filling ? int'(ram[r.addr]) : int'(ref_mem[r.addr]);
                    c.cyc = r.cyc;
                    q_cv.push_back(c);
                end
            end else if (q_rd.size() > 0 && cyc > q_rd[0].cyc + 1) begin
                chk("read_missing", 0, 1);
                void'(q_rd.pop_front());
            end
            if (char_valid) begin
                if (q_cv.size() == 0) chk("unexpected_char_valid", 1, 0);
                else begin
                    c = q_cv.pop_front();
                    chk("char_code", char_code, c.ch);
                    chk("char_latency", cyc - c.cyc, 3);
                end
            end else if (q_cv.size() > 0 && cyc > q_cv[0].cyc + 3) begin
                chk("char_valid_missing", 0, 1);
                void'(q_cv.pop_front());
            end
            if (fill_done) begin
                chk("fill_done_count", filling ? fill_idx : -1, CELLS);
                if (filling) for (int i = 0; i < CELLS; i++) ref_mem[i] = fill_val;
                filling = 0;
            end
            chk("fill_busy", fill_busy, filling && cyc > start_cyc);
            dreq = pix_tick && video_on && pixel_x[2:0] == 3'd0;
            chk("wr_ready", wr_ready, !filling && !dreq && !fill_start);
            if (fill_start && !filling) begin
                filling = 1; start_cyc = cyc; fill_val = fill_char; fill_idx = 0;
            end else if (wr_valid && wr_ready) begin
                h.drop = wr_col >= COLS || wr_row >= ROWS;
                h.addr = int'(wr_row) * COLS + int'(wr_col);
                h.ch = wr_char; h.cyc = cyc;
                q_hw.push_back(h);
                if (!h.drop) ref_mem[h.addr] = wr_char;
            end
            if (dreq) begin
                r.addr = int'(pixel_y) / 16 * COLS + int'(pixel_x) / 8;
                r.cyc  = cyc;
                q_rd.push_back(r);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        phase = (phase + 1) % 4;
        fill_start = 0;
        if (vid_rand) begin
            pix_tick = phase == 0;
            video_on = $urandom_range(0, 3) != 0;
            pixel_x  = 10'($urandom_range(0, 79) * 8 + ($urandom_range(0, 1) ? 0 : $urandom_range(0, 7)));
            pixel_y  = 9'($urandom_range(0, 479));
        end else begin
            pix_tick = 0; video_on = 0;
        end
    endtask

    task automatic host_write(input int c, input int r, input int ch, input int bound);
        bit hs;
        wr_col = 7'(c); wr_row = 5'(r); wr_char = 7'(ch); wr_valid = 1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            hs = wr_ready;
            step();
            if (hs) break;
            if (i >= bound) begin chk("host_handshake_timeout", 0, 1); break; end
        end
        wr_valid = 0;
    endtask

    task automatic mem_check(input string nm);
        int bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk(nm, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ram_en, ram_we, ram_addr, ram_wdata, char_code, char_valid,
                              wr_drop, fill_busy, fill_done}, 0);
        @(posedge clk); #1 reset = 0;
        repeat (4) begin
            @(negedge clk); chk("idle_ram_en", ram_en, 0); step();
        end
        host_write(5, 3, 'h4A, 20);
        step();
        pix_tick = 1; video_on = 1; pixel_x = 40; pixel_y = 48;
        repeat (5) step();
        chk("j_in_ram", ram[245], 'h4A);
        chk("char_code_hold", char_code, 'h4A);
        wr_col = 10; wr_row = 2; wr_char = 'h11; wr_valid = 1;
        pix_tick = 1; video_on = 1; pixel_x = 0; pixel_y = 0;
        @(negedge clk);
        chk("ready_blocked_by_disp", wr_ready, 0);
        step();
        host_write(10, 2, 'h11, 20);
        repeat (3) step();
        host_write(80, 0, 'h41, 20);
        host_write(0, 30, 'h42, 20);
        repeat (3) step();
        vid_rand = 1;
        for (int i = 0; i < 60; i++) begin
            host_write($urandom_range(0, 84), $urandom_range(0, 31), $urandom_range(0, 127), 200);
            repeat ($urandom_range(0, 5)) step();
        end
        fill_char = 'h20; fill_start = 1;
        step();
        repeat (60) step();
        fill_char = 'h33; fill_start = 1;
        step();
        host_write(1, 1, 'h5A, 8000);
        chk("fill_over_before_host", filling, 0);
        repeat (10) step();
        vid_rand = 0;
        repeat (10) step();
        mem_check("mem_after_fill");
        for (int i = 0; i < 200; i++)
            host_write($urandom_range(0, 79), $urandom_range(0, 29), $urandom_range(0, 127), 20);
        abort_cells = 1000;
        fill_char = 'h20; fill_start = 1;
        step();
        for (int i = 0; i < 3000 && fill_idx < 999; i++) step();
        chk("abort_point", fill_idx, 999);
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("busy_after_abort", fill_busy, 0);
        repeat (20) step();
        mem_check("mem_after_abort");
        host_write(7, 7, 'h7E, 20);
        repeat (6) step();
        chk("post_abort_write", ram[7 * 80 + 7], 'h7E);
        chk("queues_drained", q_rd.size() + q_cv.size() + q_hw.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_text_ram_arbiter.md
Name: vga_text_ram_arbiter

Overview:
- Shares one single-port synchronous character RAM (the text screen buffer) between two users: the VGA display fetch path and a host writer port.
- The display path has fixed-timing priority. The host writer uses a valid/ready handshake.
- A built-in fill engine clears or fills the whole screen without host involvement.
- The block sits between the VGA timing/pixel counters and the font-ROM lookup: it turns the current cell into a char code, which then drives the font ROM address.

Parameters:
- COLS, 80, text columns (640 px / 8 px per cell).
- ROWS, 30, text rows (480 px / 16 px per cell).
- ADDR_W, 12, RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W.
- DATA_W, 7, char code width (font ROM char_addr width).

Ports:
- clk  in  1  system clock (the 4x pixel clock domain).
- reset  in  1  synchronous, active-high.
- pix_tick  in  1  one-clk strobe per pixel (once per 4 clk).
- video_on  in  1  active-video flag.
- pixel_x  in  10  current active pixel column, 0..639.
- pixel_y  in  9  current active pixel row, 0..479.
- char_code  out  DATA_W  fetched char code for the font ROM.
- char_valid  out  1  one-clk pulse when char_code updates.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle when wr_valid is also high.
- wr_col  in  7  target column.
- wr_row  in  5  target row.
- wr_char  in  DATA_W  char code to write.
- wr_drop  out  1  one-clk pulse: accepted write was out of range and discarded.
- fill_start  in  1  one-clk request to fill the whole screen.
- fill_char  in  DATA_W  fill value, sampled on fill_start acceptance (0 gives a clear).
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-clk pulse after the last cell is written.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 clk after en with we=0.

Behaviour:
- Reset is synchronous and active-high on clk.
  - All outputs go to 0: ram_*, char_code, char_valid, wr_drop, fill_busy, fill_done.
  - The FSM goes to IDLE and the fill counter goes to 0.
- Display request: disp_req = pix_tick & video_on & (pixel_x[2:0]==0).
  - Cell address = pixel_y[8:4]*COLS + pixel_x[9:3], computed in ADDR_W bits with no overflow.
- Arbitration priority each clk: disp_req > fill > host write. Exactly one RAM command is issued per clk, or none.
- RAM command outputs are registered. A command decided at cycle N appears on the ram_* pins at N+1.
- Display read latency:
  - disp_req at N gives a read on the RAM pins at N+1.
  - ram_rdata is valid at N+2.
  - char_code is registered and char_valid pulses at N+3.
  - Total is 3 clk, which is under the 4-clk pixel period.
- char_code holds its value between fetches.
- FSM states: IDLE and FILL.
- IDLE:
  - wr_ready = !disp_req & !fill_start (combinational).
  - On wr_valid & wr_ready:
    - If wr_col < COLS and wr_row < ROWS, issue a write of wr_char at wr_row*COLS + wr_col.
    - Otherwise issue no RAM command and pulse wr_drop at N+1.
  - fill_start moves the FSM to FILL, latches fill_char and clears the counter. fill_start beats a simultaneous wr_valid, and that write is not accepted.
- FILL:
  - fill_busy = 1 and wr_ready = 0.
  - On each clk without disp_req, write the latched char at counter address, then increment the counter.
  - On clks with disp_req, issue the display read instead and hold the counter.
  - After writing address COLS*ROWS-1, return to IDLE and pulse fill_done on the next clk.
  - fill_start while in FILL is ignored.
- Reset mid-fill aborts the fill. Cells already written stay written, and fill_done does not pulse.
- Host writes held by disp_req simply see wr_ready low. The host must hold wr_valid and its data stable until the handshake.
- ram_en = 0 on cycles with no command.
- ram_we = 1 only for host or fill writes.

Decomposition:
- Package vga_text_pkg holds:
  - constants COLS, ROWS, CELLS = COLS*ROWS and ADDR_W;
  - state enum {IDLE, FILL};
  - command-source enum {SRC_NONE, SRC_DISP, SRC_FILL, SRC_HOST}.
- One sub-module, vga_cell_addr: combinational row*COLS+col using shift-add (row<<6 + row<<4 for COLS=80), instantiated twice (display and host).

Test Plan:
- Reset, then idle with video_on=0 -> all outputs 0; wr_ready=1 with no ram_en activity.
- Host writes 'J' (0x4A) at col 5, row 3 while video is idle -> ram_we=1, ram_addr=245, ram_wdata=0x4A one clk after the handshake. Then scan pixel_x=40, pixel_y=48 with the RAM model -> char_code=0x4A, char_valid pulse 3 clk after the pix_tick.
- wr_valid held while disp_req fires -> wr_ready=0 that clk, display read issued; write accepted on the next clk with no loss or duplication.
- Write to col 80, row 0 and to col 0, row 30 -> wr_drop pulses, no ram_en.
- fill_start with fill_char=0x20 during active video -> fill_busy high; all 2400 addresses written exactly once with 0x20; display reads interleaved and still 3-clk latency; fill_done single pulse; host blocked throughout.
- Reset asserted at fill counter 1000 -> next clk fill_busy=0, no fill_done; cells 0..999 hold 0x20 and the rest are unchanged; a subsequent host write proceeds normally.
